// File: rtl/serial_add4.sv
// Bit-serial unsigned adder: one full-adder cell and a carry flop are reused
// over WIDTH clocks, LSB first, behind a START/BUSY/DONE handshake.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one operand bit pair consumed per clock, LSB first
// FIN   | result just published, done high; start here restarts at once
module serial_add4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, ps;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s, c_nxt, last, load;

  assign s     = sa[0] ^ sb[0] ^ c;
  assign c_nxt = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
  assign last  = (state == RUN) && (cnt == LAST);
  // start is honoured in IDLE and FIN only; during RUN it is ignored
  assign load  = start && (state != RUN);
  assign busy  = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = FIN;
      FIN:     state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= last;
      if (load) begin
        sa  <= a;
        sb  <= b;
        ps  <= '0;
        c   <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        ps  <= {s, ps[WIDTH-1:1]};
        c   <= c_nxt;
        cnt <= cnt + CW'(1);
      end
      // publish on the same edge that raises done, including the final bit
      if (last) begin
        sum  <= {s, ps[WIDTH-1:1]};
        cout <= c_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_add4.sv
// Self-checking bench for serial_add4: a cycle-level reference model compared
// every cycle, plus directed literal expectations.
module tb_serial_add4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy, done, cout;
  logic [3:0] sum;

  int total = 0;
  int bad = 0;

  serial_add4 #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: an accepted request finishes 4 edges later with a+b.
  int         run_left = 0;
  logic [4:0] pend = '0;
  logic       m_done = 1'b0;
  logic [3:0] m_sum = '0;
  logic       m_cout = 1'b0;
  logic       prev_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_left <= 0;
      pend     <= '0;
      m_done   <= 1'b0;
      m_sum    <= '0;
      m_cout   <= 1'b0;
    end else if (run_left > 0) begin
      run_left <= run_left - 1;
      m_done   <= (run_left == 1);
      if (run_left == 1) begin
        m_sum  <= pend[3:0];
        m_cout <= pend[4];
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        pend     <= {1'b0, a} + {1'b0, b};
        run_left <= 4;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, run_left > 0);
    check("done", done, m_done);
    check("sum", sum, m_sum);
    check("cout", cout, m_cout);
    check("done_twice", done && prev_done, 0);
    prev_done <= done;
  end

  task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] es, input logic ec);
    int n;
    int nb;
    n  = 0;
    nb = 0;
    @(negedge clk);
    #1;
    start = 1'b1;
    a = av;
    b = bv;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        n = i;
        break;
      end
      if (i == 1) begin
        #1;
        start = 1'b0;
        a = ~av;
        b = ~bv;
      end
    end
    check($sformatf("latency a=%0d b=%0d", av, bv), n, 5);
    check($sformatf("busy_cycles a=%0d b=%0d", av, bv), nb, 4);
    check($sformatf("sum a=%0d b=%0d", av, bv), sum, es);
    check($sformatf("cout a=%0d b=%0d", av, bv), cout, ec);
  endtask

  initial begin
    int dn;
    int first;
    logic [4:0] full;

    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // basic add and hold
    run_op(4'd3, 4'd5, 4'd8, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_sum", sum, 8);
    check("hold_busy", busy, 0);

    // overflow and zero cases
    run_op(4'd15, 4'd1, 4'd0, 1'b1);
    run_op(4'd15, 4'd15, 4'd14, 1'b1);
    run_op(4'd0, 4'd0, 4'd0, 1'b0);

    // start while busy is ignored
    @(negedge clk);
    #1 start = 1'b1; a = 4'd2; b = 4'd2;
    @(negedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    #1 start = 1'b1; a = 4'd9; b = 4'd9;
    @(negedge clk);
    #1 start = 1'b0;
    dn = 0;
    first = 0;
    for (int i = 4; i <= 14; i++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (first == 0) first = i;
      end
    end
    check("busy_start_latency", first, 5);
    check("busy_start_dones", dn, 1);
    check("busy_start_sum", sum, 4);
    check("busy_start_cout", cout, 0);

    // back-to-back
    @(negedge clk);
    #1 start = 1'b1; a = 4'd7; b = 4'd8;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) begin
        first = i;
        break;
      end
    end
    check("b2b_first_latency", first, 5);
    check("b2b_first_sum", sum, 15);
    #1 a = 4'd1; b = 4'd1;
    first = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (done) begin
        first = j;
        break;
      end
      if (j == 1) begin
        #1 start = 1'b0;
      end
    end
    check("b2b_second_latency", first, 5);
    check("b2b_second_sum", sum, 2);
    check("b2b_second_cout", cout, 0);

    // reset mid-run
    @(negedge clk);
    #1 start = 1'b1; a = 4'd9; b = 4'd9;
    @(negedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("midrst_no_done", dn, 0);
    run_op(4'd4, 4'd4, 4'd8, 1'b0);

    // exhaustive
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        full = 5'(x) + 5'(y);
        run_op(4'(x), 4'(y), full[3:0], full[4]);
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
